// File: rtl/stream_ser.sv
// ---------------------------------------------------------------------------
// stream_ser -- valid/ready width-down serializer.
//
// Accepts one wide word (RATIO beats of DATA_W bits) on the input stream and
// emits it as RATIO narrow beats on the output stream. The next word is
// accepted in the same cycle the last beat of the current word leaves, so
// back-to-back words stream with no bubble.
//
// Parameters:
//   DATA_W  width of one output beat in bits
//   RATIO   output beats per input word (2..256, any value in that range)
//
// Ports:
//   clk      in   single clock, rising edge
//   reset_n  in   asynchronous active-low reset
//   i_data   in   wide input word (DATA_W*RATIO bits)
//   i_valid  in   input word valid
//   i_ready  out  block can accept a word this cycle
//   o_data   out  current output beat
//   o_valid  out  output beat valid
//   o_ready  in   downstream accepts beat
//   o_last   out  current beat is the final beat of its word
//
// Build option:
//   STREAM_SER_MSB_FIRST_EN  defined   -> beats leave MSB slice first
//                            undefined -> beats leave LSB slice first
// ---------------------------------------------------------------------------
module stream_ser #(
  parameter int DATA_W = 8,
  parameter int RATIO  = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [DATA_W*RATIO-1:0]  i_data,
  input  logic                     i_valid,
  output logic                     i_ready,
  output logic [DATA_W-1:0]        o_data,
  output logic                     o_valid,
  input  logic                     o_ready,
  output logic                     o_last
);

  localparam int CNT_W = $clog2(RATIO);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RATIO - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic {EMP = 1'b0, LOADED = 1'b1} st_t;

  st_t                     st_q, st_d;
  logic [DATA_W*RATIO-1:0] buf_q, buf_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  logic in_fire;
  logic out_fire;
  logic last_fire;
  logic cnt_at_last;

  // Beat k of the held word, already reordered for the selected beat order,
  // so the output mux is a plain index by the counter.
  logic [DATA_W-1:0] beat [RATIO];

  genvar gi;
  generate
    for (gi = 0; gi < RATIO; gi++) begin : g_beat
`ifdef STREAM_SER_MSB_FIRST_EN
      assign beat[gi] = buf_q[(RATIO-1-gi)*DATA_W +: DATA_W];
`else
      assign beat[gi] = buf_q[gi*DATA_W +: DATA_W];
`endif
    end
  endgenerate

  assign cnt_at_last = (cnt_q == CNT_LAST);
  assign out_fire    = o_valid && o_ready;
  assign last_fire   = out_fire && cnt_at_last;
  assign in_fire     = i_valid && i_ready;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st_q  <= EMP;
      buf_q <= '0;
      cnt_q <= '0;
    end else begin
      st_q  <= st_d;
      buf_q <= buf_d;
      cnt_q <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    st_d  = st_q;
    buf_d = buf_q;
    cnt_d = cnt_q;
    case (st_q)
      EMP: begin
        if (in_fire) begin
          buf_d = i_data;
          cnt_d = '0;
          st_d  = LOADED;
        end
      end
      LOADED: begin
        if (out_fire) begin
          if (cnt_at_last) begin
            cnt_d = '0;
            // i_ready is high on last_fire, so in_fire == i_valid here:
            // either refill in place or drain to empty.
            if (in_fire) begin
              buf_d = i_data;
              st_d  = LOADED;
            end else begin
              st_d  = EMP;
            end
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end
      default: begin
        st_d  = EMP;
        cnt_d = '0;
      end
    endcase
  end

  // Output logic. i_ready depends combinationally on o_ready through
  // last_fire; that path is what makes the refill zero-bubble.
  always_comb begin
    o_valid = (st_q == LOADED);
    o_last  = (st_q == LOADED) && cnt_at_last;
    i_ready = (st_q == EMP) || last_fire;
    o_data  = beat[cnt_q];
  end

endmodule

// File: tb/tb_stream_ser.sv
// ---------------------------------------------------------------------------
// tb_stream_ser -- directed, table-driven bench for stream_ser
// (DATA_W=8, RATIO=4). Each table row is one clock cycle: the inputs driven
// in that cycle and the outputs expected before the next rising edge.
// Reset-mid-word and idle-start sequences are written out by hand.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_stream_ser;

  localparam int DATA_W = 8;
  localparam int RATIO  = 4;

  logic        clk;
  logic        reset_n;
  logic [31:0] i_data;
  logic        i_valid;
  logic        i_ready;
  logic [7:0]  o_data;
  logic        o_valid;
  logic        o_ready;
  logic        o_last;

  int n_checks = 0;
  int n_pass   = 0;

  stream_ser #(.DATA_W(DATA_W), .RATIO(RATIO)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .i_data  (i_data),
    .i_valid (i_valid),
    .i_ready (i_ready),
    .o_data  (o_data),
    .o_valid (o_valid),
    .o_ready (o_ready),
    .o_last  (o_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        iv;
    logic [31:0] d;
    logic        ordy;
    logic        e_irdy;
    logic        e_ov;
    logic [7:0]  e_od;
    logic        e_ol;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input logic iv, input logic [31:0] d, input logic ordy,
                             input logic e_irdy, input logic e_ov, input logic [7:0] e_od,
                             input logic e_ol);
    vec_t r;
    r.iv = iv; r.d = d; r.ordy = ordy;
    r.e_irdy = e_irdy; r.e_ov = e_ov; r.e_od = e_od; r.e_ol = e_ol;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // One cycle: drive inputs just after an edge, check at the falling edge,
  // advance past the next rising edge. o_data is compared only while valid.
  task automatic cycle(input string tag, input vec_t r);
    i_valid = r.iv;
    i_data  = r.d;
    o_ready = r.ordy;
    @(negedge clk);
    chk({tag, " i_ready"}, {31'd0, i_ready}, {31'd0, r.e_irdy});
    chk({tag, " o_valid"}, {31'd0, o_valid}, {31'd0, r.e_ov});
    chk({tag, " o_last"},  {31'd0, o_last},  {31'd0, r.e_ol});
    if (r.e_ov) chk({tag, " o_data"}, {24'd0, o_data}, {24'd0, r.e_od});
    $display("%s: iv=%0b irdy=%0b ov=%0b od=%02h last=%0b ordy=%0b",
             tag, r.iv, i_ready, o_valid, o_data, o_last, r.ordy);
    @(posedge clk);
    #1;
  endtask

  logic [7:0] rw_exp [4];

  initial begin
`ifdef STREAM_SER_MSB_FIRST_EN
    // Single word, MSB first: DD, CC, BB, AA with last on AA
    tbl.push_back(v(1, 32'hDDCCBBAA, 1, 1, 0, 8'h00, 0));
    tbl.push_back(v(0, 32'h0,        1, 0, 1, 8'hDD, 0));
    tbl.push_back(v(0, 32'h0,        1, 0, 1, 8'hCC, 0));
    tbl.push_back(v(0, 32'h0,        1, 0, 1, 8'hBB, 0));
    tbl.push_back(v(0, 32'h0,        1, 1, 1, 8'hAA, 1));
    tbl.push_back(v(0, 32'h0,        1, 1, 0, 8'h00, 0));
    rw_exp[0] = 8'h03; rw_exp[1] = 8'h02; rw_exp[2] = 8'h01; rw_exp[3] = 8'h00;
`else
    // Single word
    tbl.push_back(v(1, 32'hDDCCBBAA, 1, 1, 0, 8'h00, 0));
    tbl.push_back(v(0, 32'h0,        1, 0, 1, 8'hAA, 0));
    tbl.push_back(v(0, 32'h0,        1, 0, 1, 8'hBB, 0));
    tbl.push_back(v(0, 32'h0,        1, 0, 1, 8'hCC, 0));
    tbl.push_back(v(0, 32'h0,        1, 1, 1, 8'hDD, 1));
    tbl.push_back(v(0, 32'h0,        1, 1, 0, 8'h00, 0));
    // Back-to-back, i_valid held; refill on the 0x44 beat, no bubble
    tbl.push_back(v(1, 32'h44332211, 1, 1, 0, 8'h00, 0));
    tbl.push_back(v(1, 32'h88776655, 1, 0, 1, 8'h11, 0));
    tbl.push_back(v(1, 32'h88776655, 1, 0, 1, 8'h22, 0));
    tbl.push_back(v(1, 32'h88776655, 1, 0, 1, 8'h33, 0));
    tbl.push_back(v(1, 32'h88776655, 1, 1, 1, 8'h44, 1));
    tbl.push_back(v(0, 32'h0,        1, 0, 1, 8'h55, 0));
    tbl.push_back(v(0, 32'h0,        1, 0, 1, 8'h66, 0));
    tbl.push_back(v(0, 32'h0,        1, 0, 1, 8'h77, 0));
    tbl.push_back(v(0, 32'h0,        1, 1, 1, 8'h88, 1));
    tbl.push_back(v(0, 32'h0,        1, 1, 0, 8'h00, 0));
    // Backpressure, o_ready 1,0,0,1,... ; junk i_data with i_valid low is ignored
    tbl.push_back(v(1, 32'hDDCCBBAA, 0, 1, 0, 8'h00, 0));
    tbl.push_back(v(0, 32'h12345678, 1, 0, 1, 8'hAA, 0));
    tbl.push_back(v(0, 32'h12345678, 0, 0, 1, 8'hBB, 0));
    tbl.push_back(v(0, 32'h12345678, 0, 0, 1, 8'hBB, 0));
    tbl.push_back(v(0, 32'h12345678, 1, 0, 1, 8'hBB, 0));
    tbl.push_back(v(1, 32'h9ABCDEF0, 0, 0, 1, 8'hCC, 0));
    tbl.push_back(v(1, 32'h9ABCDEF0, 0, 0, 1, 8'hCC, 0));
    tbl.push_back(v(0, 32'h12345678, 1, 0, 1, 8'hCC, 0));
    tbl.push_back(v(0, 32'h12345678, 0, 0, 1, 8'hDD, 1));
    tbl.push_back(v(0, 32'h12345678, 1, 1, 1, 8'hDD, 1));
    tbl.push_back(v(0, 32'h0,        1, 1, 0, 8'h00, 0));
    rw_exp[0] = 8'h00; rw_exp[1] = 8'h01; rw_exp[2] = 8'h02; rw_exp[3] = 8'h03;
`endif

    reset_n = 1'b0;
    i_valid = 1'b0;
    i_data  = '0;
    o_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("reset o_valid", {31'd0, o_valid}, 32'd0);
    chk("reset o_last",  {31'd0, o_last},  32'd0);
    chk("reset o_data",  {24'd0, o_data},  32'd0);
    chk("reset i_ready", {31'd0, i_ready}, 32'd1);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++)
      cycle($sformatf("vec%0d", i), tbl[i]);

    // Reset mid-word: load, let beat 0 and beat 1 leave, then reset
    cycle("rst load", v(1, 32'hDDCCBBAA, 1, 1, 0, 8'h00, 0));
    cycle("rst b0",   v(0, 32'h0, 1, 0, 1, (rw_exp[0] == 8'h00) ? 8'hAA : 8'hDD, 0));
    cycle("rst b1",   v(0, 32'h0, 1, 0, 1, (rw_exp[0] == 8'h00) ? 8'hBB : 8'hCC, 0));
    reset_n = 1'b0;
    #1;
    chk("midrst o_valid", {31'd0, o_valid}, 32'd0);
    chk("midrst o_data",  {24'd0, o_data},  32'd0);
    chk("midrst o_last",  {31'd0, o_last},  32'd0);
    chk("midrst i_ready", {31'd0, i_ready}, 32'd1);
    $display("midrst: ov=%0b od=%02h irdy=%0b", o_valid, o_data, i_ready);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Idle start: nothing offered for 10 cycles, then a fresh word
    for (int i = 0; i < 10; i++)
      cycle($sformatf("idle%0d", i), v(0, 32'hFFFFFFFF, 1, 1, 0, 8'h00, 0));
    cycle("new load", v(1, 32'h03020100, 1, 1, 0, 8'h00, 0));
    for (int k = 0; k < 4; k++)
      cycle($sformatf("new b%0d", k),
            v(0, 32'h0, 1, (k == 3), 1, rw_exp[k], (k == 3)));
    cycle("new done", v(0, 32'h0, 1, 1, 0, 8'h00, 0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
